gmsk_burst_sequencer: RTL and testbench

- Timing and burst controller in front of gmsk_tx.
- Generates the sample_strobe/symbol_strobe cadence and frames one normal burst: head tail bits, payload bits, tail bits, guard period.
- Pulls payload bits from an upstream bit source using a valid/ready handshake.
- Presents each bit to the modulator's input_bit on the symbol_strobe cycle, and reports burst status to the burst scheduler above.

---
 rtl/gmsk_burst_sequencer.sv | 142 ++++++++++++++
 tb/tb_gmsk_burst_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gmsk_burst_sequencer.sv
// Burst framing and strobe timing in front of gmsk_tx.
// Frames HEAD tail zeros, PAYLOAD bits pulled from a valid/ready source,
// TAIL zeros and a GUARD period, driving sample/symbol strobes throughout.
module gmsk_burst_sequencer #(
  parameter int SAMPLE_DIV         = 2,
  parameter int SAMPLES_PER_SYMBOL = 128,
  parameter int TAIL_BITS          = 3,
  parameter int PAYLOAD_BITS       = 142,
  parameter int GUARD_BITS         = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic burst_start,
  input  logic abort,
  input  logic bit_valid,
  input  logic bit_data,
  output logic bit_ready,
  output logic symbol_strobe,
  output logic sample_strobe,
  output logic mod_bit,
  output logic tx_active,
  output logic busy,
  output logic burst_done,
  output logic underrun
);

  localparam int DW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW   = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int MAXA = (TAIL_BITS > PAYLOAD_BITS) ? TAIL_BITS : PAYLOAD_BITS;
  localparam int MAXB = (MAXA > GUARD_BITS) ? MAXA : GUARD_BITS;
  localparam int BW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_PAYLOAD, S_TAIL, S_GUARD} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            mod_bit_q, mod_bit_d;
  logic            underrun_q, underrun_d;
  logic            abort_pend_q, abort_pend_d;

  logic running, samp_end, sym_end, abort_any, cur_bit;

  // Strobe cadence and the per-symbol source handshake
  always_comb begin
    running       = (state_q != S_IDLE);
    samp_end      = (div_cnt_q == DW'(SAMPLE_DIV - 1));
    sym_end       = samp_end && (samp_cnt_q == SW'(SAMPLES_PER_SYMBOL - 1));
    sample_strobe = running && samp_end;
    symbol_strobe = running && (div_cnt_q == '0) && (samp_cnt_q == '0);
    // An abort seen on the boundary clock itself still counts this symbol
    abort_any     = abort_pend_q ||
                    (abort && (state_q == S_HEAD || state_q == S_PAYLOAD));
    bit_ready     = symbol_strobe && (state_q == S_PAYLOAD) && !abort_any;
    cur_bit       = bit_ready && bit_valid && bit_data;
  end

  assign mod_bit   = running && (symbol_strobe ? cur_bit : mod_bit_q);
  assign tx_active = (state_q == S_HEAD) || (state_q == S_PAYLOAD) || (state_q == S_TAIL);
  assign busy      = running;
  assign underrun  = underrun_q;

  // Next-state: counters, framing FSM, underrun and abort bookkeeping
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = '0;
    samp_cnt_d   = '0;
    bit_cnt_d    = bit_cnt_q;
    mod_bit_d    = mod_bit_q;
    underrun_d   = underrun_q;
    abort_pend_d = abort_any;
    burst_done   = 1'b0;

    if (running) begin
      div_cnt_d  = samp_end ? '0 : div_cnt_q + DW'(1);
      samp_cnt_d = samp_end ? (sym_end ? '0 : samp_cnt_q + SW'(1)) : samp_cnt_q;
      if (symbol_strobe) begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        mod_bit_d = cur_bit;
      end
      if (bit_ready && !bit_valid) underrun_d = 1'b1;
    end

    // Transitions land on the last clock of a symbol period so the
    // following symbol_strobe belongs to the new state
    case (state_q)
      S_IDLE: begin
        mod_bit_d = 1'b0;
        if (burst_start) begin
          state_d    = S_HEAD;
          underrun_d = 1'b0;
        end
      end
      S_HEAD: begin
        if (sym_end) begin
          if (abort_any)                          state_d = S_TAIL;
          else if (bit_cnt_q == BW'(TAIL_BITS))   state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (sym_end && (abort_any || bit_cnt_q == BW'(PAYLOAD_BITS))) state_d = S_TAIL;
      end
      S_TAIL: begin
        if (sym_end && bit_cnt_q == BW'(TAIL_BITS)) state_d = S_GUARD;
      end
      S_GUARD: begin
        if (sym_end && bit_cnt_q == BW'(GUARD_BITS)) begin
          state_d    = S_IDLE;
          burst_done = 1'b1;
          mod_bit_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) bit_cnt_d = '0;
    if (state_d != S_HEAD && state_d != S_PAYLOAD) abort_pend_d = 1'b0;
  end

  // State registers, async active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      mod_bit_q    <= 1'b0;
      underrun_q   <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      mod_bit_q    <= mod_bit_d;
      underrun_q   <= underrun_d;
      abort_pend_q <= abort_pend_d;
    end
  end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Directed bench: small-config instance for framing/abort/underrun/reset,
// default-config instance for full-length burst timing.
module tb_gmsk_burst_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  logic burst_start, abort, bit_valid, bit_data;
  logic bit_ready, symbol_strobe, sample_strobe, mod_bit, tx_active, busy, burst_done, underrun;
  logic b_start;
  logic b_ready, b_sym, b_samp, b_mod, b_act, b_busy, b_done, b_under;

  always #5 clock = ~clock;

  gmsk_burst_sequencer #(.SAMPLE_DIV(2), .SAMPLES_PER_SYMBOL(4), .TAIL_BITS(3),
                         .PAYLOAD_BITS(4), .GUARD_BITS(2)) dut (
    .clock(clock), .reset_n(reset_n), .burst_start(burst_start), .abort(abort),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .symbol_strobe(symbol_strobe), .sample_strobe(sample_strobe), .mod_bit(mod_bit),
    .tx_active(tx_active), .busy(busy), .burst_done(burst_done), .underrun(underrun));

  gmsk_burst_sequencer dut_d (
    .clock(clock), .reset_n(reset_n), .burst_start(b_start), .abort(1'b0),
    .bit_valid(1'b1), .bit_data(1'b1), .bit_ready(b_ready),
    .symbol_strobe(b_sym), .sample_strobe(b_samp), .mod_bit(b_mod),
    .tx_active(b_act), .busy(b_busy), .burst_done(b_done), .underrun(b_under));

  int errors = 0, checks = 0;
  // small-instance observation state
  int cyc, n_sym, n_samp, n_act, n_grd, n_ready, pops, last_sym, last_samp;
  int first_sym, done_cyc, sym_bad, samp_bad, overlap, drop_idx;
  bit done_seen, inj, ab_en;
  logic [15:0] seq;
  logic [3:0]  pat = 4'b1101;   // payload bits 1,0,1,1 (index 0 first)
  // default-instance observation state
  int bsym, bact, bgrd, bready, blast, bbad;
  bit bdone;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; n_sym = 0; n_samp = 0; n_act = 0; n_grd = 0; n_ready = 0; pops = 0;
    last_sym = 0; last_samp = 0; first_sym = 0; done_cyc = 0; sym_bad = 0;
    samp_bad = 0; overlap = 0; done_seen = 0; seq = '0;
    bsym = 0; bact = 0; bgrd = 0; bready = 0; blast = 0; bbad = 0; bdone = 0;
  endtask

  // One clock: drive inputs just after the edge, sample 1ns later
  task automatic tick();
    @(posedge clock); #1;
    burst_start = inj && (n_sym == 5 || n_sym == 11) && (cyc + 1 - last_sym == 3);
    abort       = ab_en && (n_sym == 5) && (cyc + 1 - last_sym == 4);
    bit_valid   = (pops != drop_idx);
    bit_data    = pat[pops % 4];
    b_start     = 1'b0;
    #1;
    cyc++;
    if (symbol_strobe) begin
      if (n_sym > 0 && cyc - last_sym != 8) sym_bad++;
      if (n_sym == 0) first_sym = cyc;
      last_sym = cyc; n_sym++;
      seq = {seq[14:0], mod_bit};
      if (tx_active) n_act++;
      if (busy && !tx_active) n_grd++;
    end
    if (sample_strobe) begin
      if (n_samp > 0 && cyc - last_samp != 2) samp_bad++;
      last_samp = cyc; n_samp++;
    end
    if (sample_strobe && symbol_strobe) overlap++;
    if (bit_ready) begin n_ready++; pops++; end
    if (burst_done) begin done_seen = 1; done_cyc = cyc; end
    if (b_sym) begin
      if (bsym > 0 && cyc - blast != 256) bbad++;
      blast = cyc; bsym++;
      if (b_act) bact++;
      if (b_busy && !b_act) bgrd++;
    end
    if (b_samp && b_sym) bbad++;
    if (b_ready) bready++;
    if (b_done) bdone = 1;
  endtask

  task automatic run_a(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) tick();
    chk("done_reached", int'(done_seen), 1);
  endtask

  initial begin
    reset_n = 1'b0; burst_start = 0; abort = 0; bit_valid = 0; bit_data = 0; b_start = 0;
    inj = 0; ab_en = 0; drop_idx = -1;
    clr();
    #2;
    chk("reset_outputs", int'({bit_ready, symbol_strobe, sample_strobe, mod_bit,
                               tx_active, busy, burst_done, underrun}), 0);
    #10 reset_n = 1'b1;
    tick(); tick();
    chk("idle_no_strobes", n_sym + n_samp, 0);

    // 1: nominal burst, valid source 1,0,1,1
    clr(); burst_start = 1; tick();
    chk("t1_first_strobe_cycle", first_sym, 1);
    run_a(200);
    chk("t1_mod_seq", int'(seq), 'h160);
    chk("t1_symbols", n_sym, 12);
    chk("t1_tx_active_syms", n_act, 10);
    chk("t1_guard_syms", n_grd, 2);
    chk("t1_done_span", done_cyc - first_sym + 1, 96);
    chk("t1_ready", n_ready, 4);
    chk("t1_samples", n_samp, 48);
    chk("t1_cadence", sym_bad + samp_bad + overlap, 0);
    chk("t1_underrun", int'(underrun), 0);

    // 2: bit_valid low on the 3rd payload symbol
    tick(); clr(); drop_idx = 2; burst_start = 1; tick();
    run_a(200);
    drop_idx = -1;
    chk("t2_mod_seq", int'(seq), 'h120);
    chk("t2_ready", n_ready, 4);
    tick(); tick(); tick();
    chk("t2_underrun_held_idle", int'({underrun, busy}), 2);

    // 3: abort mid-way through the 2nd payload symbol
    clr(); ab_en = 1; burst_start = 1; tick();
    chk("t3_underrun_cleared", int'(underrun), 0);
    run_a(200);
    ab_en = 0;
    chk("t3_ready", n_ready, 2);
    chk("t3_mod_seq", int'(seq), 'h040);
    chk("t3_symbols", n_sym, 10);
    chk("t3_tx_active_syms", n_act, 8);
    chk("t3_guard_syms", n_grd, 2);
    chk("t3_done_span", done_cyc - first_sym + 1, 80);

    // 4: burst_start re-pulsed in PAYLOAD and GUARD, then restart right after done
    tick(); clr(); inj = 1; burst_start = 1; tick();
    run_a(200);
    inj = 0;
    chk("t4_symbols", n_sym, 12);
    chk("t4_done_span", done_cyc - first_sym + 1, 96);
    chk("t4_mod_seq", int'(seq), 'h160);
    tick();
    chk("t4_idle_after_done", int'(busy), 0);
    clr(); burst_start = 1; tick();
    chk("t4_restart_strobe", first_sym, 1);
    run_a(200);
    chk("t4_restart_symbols", n_sym, 12);
    chk("t4_restart_ready", n_ready, 4);

    // 5: async reset during PAYLOAD
    tick(); clr(); burst_start = 1; tick();
    for (int i = 0; i < 100 && n_sym < 5; i++) tick();
    chk("t5_in_payload", n_sym, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_outputs", int'({bit_ready, symbol_strobe, sample_strobe, mod_bit,
                                  tx_active, busy, burst_done, underrun}), 0);
    #2 reset_n = 1'b1;
    clr();
    for (int i = 0; i < 20; i++) tick();
    chk("t5_idle_after_release", n_sym + n_samp + int'(busy), 0);

    // 6: default parameters, continuous valid source
    clr(); b_start = 1; tick();
    for (int i = 0; i < 45000 && !bdone; i++) tick();
    chk("t6_done_reached", int'(bdone), 1);
    chk("t6_symbols", bsym, 156);
    chk("t6_active_syms", bact, 148);
    chk("t6_guard_syms", bgrd, 8);
    chk("t6_ready", bready, 142);
    chk("t6_period", bbad, 0);
    chk("t6_underrun", int'(b_under), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
